nco_sine_lut: RTL

//  Downstream of the phase accumulator in the split-IO NCO.
//  - Upstream delivers a folded quarter-wave address 2 bits per clock on Aout while Vld is high, plus a sign flag on ISout.
//  - This block reassembles the address, reads a registered quarter-wave sine ROM, applies the sign, and emits one signed sample per word.

---
 rtl/nco_sine_lut_if.sv | 22 ++
 rtl/nco_sine_lut.sv | 118 +++++++++++
 2 files changed

// File: rtl/nco_sine_lut_if.sv
// rtl/nco_sine_lut_if.sv - beat-serial address in, signed sample out
interface nco_sine_lut_if #(
  parameter int DATA_W = 8
);
  logic                     en;
  logic                     vld;
  logic [1:0]               aout;
  logic                     isout;
  logic signed [DATA_W-1:0] dout;
  logic                     dvld;
  logic                     err;

  modport master (
    output en, vld, aout, isout,
    input  dout, dvld, err
  );

  modport slave (
    input  en, vld, aout, isout,
    output dout, dvld, err
  );
endinterface

// File: rtl/nco_sine_lut.sv
// rtl/nco_sine_lut.sv - quarter-wave sine lookup fed by 2-bit address beats
module nco_sine_lut #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  nco_sine_lut_if.slave  bus
);
  localparam int N     = ADDR_W / 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int SR_W  = ADDR_W - 2;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int MAG_W = DATA_W - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Elaboration-time sine in Q30 fixed point (Taylor series, angle < pi/2).
  // Entry k samples the centre of its bin, so no entry sits exactly on 0 or the peak.
  function automatic logic [MAG_W-1:0] sine_val(input int k);
    longint x, x2, term, sum, amp;
    x    = (64'sd3373259426 * longint'(2 * k + 1)) >>> (ADDR_W + 2);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int n = 1; n <= 9; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    amp = (64'sd1 <<< MAG_W) - 64'sd1;
    return MAG_W'((sum * amp + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [MAG_W-1:0] rom_tab [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom_tab[k] = sine_val(k);
  end

  logic [CNT_W-1:0]         cnt;
  logic [SR_W-1:0]          addr_sr;
  logic                     sign_l;
  logic [ADDR_W-1:0]        addr_q;
  logic                     addr_sign;
  logic                     addr_vld;
  logic [MAG_W-1:0]         mag;
  logic                     mag_sign;
  logic                     mag_vld;
  logic signed [DATA_W-1:0] mag_s;

  assign mag_s = {1'b0, mag};

  // Collect stage: assemble one address word from N beats, flag words cut short.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      addr_sr   <= '0;
      sign_l    <= 1'b0;
      addr_q    <= '0;
      addr_sign <= 1'b0;
      addr_vld  <= 1'b0;
      bus.err   <= 1'b0;
    end else if (!bus.en) begin
      cnt      <= '0;
      addr_vld <= 1'b0;
      bus.err  <= 1'b0;
    end else begin
      addr_vld <= 1'b0;
      bus.err  <= 1'b0;
      if (bus.vld) begin
        if (cnt == LAST) begin
          addr_q    <= {addr_sr, bus.aout};
          addr_sign <= sign_l;
          addr_vld  <= 1'b1;
          cnt       <= '0;
        end else begin
          addr_sr <= SR_W'({addr_sr, bus.aout});
          cnt     <= cnt + 1'b1;
          if (cnt == '0) begin
            sign_l <= bus.isout;
          end
        end
      end else if (cnt != '0) begin
        cnt     <= '0;
        bus.err <= 1'b1;
      end
    end
  end

  // ROM stage: registered table read, sign and valid ride alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag      <= '0;
      mag_sign <= 1'b0;
      mag_vld  <= 1'b0;
    end else if (!bus.en) begin
      mag_vld <= 1'b0;
    end else begin
      mag      <= rom_tab[addr_q];
      mag_sign <= addr_sign;
      mag_vld  <= addr_vld;
    end
  end

  // Output stage: apply sign, hold the sample between valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.dout <= '0;
      bus.dvld <= 1'b0;
    end else if (!bus.en) begin
      bus.dvld <= 1'b0;
    end else begin
      bus.dvld <= mag_vld;
      if (mag_vld) begin
        bus.dout <= mag_sign ? -mag_s : mag_s;
      end
    end
  end
endmodule
